uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
Serial receiver that deserializes the asynchronous 8N1 line on serial_in into bytes for the matrix_mult datapath. It takes the same 14-bit bit_period (clocks per bit) that drives the transmit side, so both directions share one baud setting. It presents each byte with a valid/ready handshake and flags framing and overrun errors.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first
BP_WIDTH, 14, width of bit_period
MIN_PERIOD, 4, lower clamp applied to bit_period

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
serial_in  input  1  raw asynchronous serial line, idle high
bit_period  input  BP_WIDTH  clocks per bit; sampled at frame start
rx_ready  input  1  consumer accepts rx_data when high with rx_valid
rx_data  output  DATA_BITS  received byte, stable while rx_valid
rx_valid  output  1  byte available; held until accepted
rx_busy  output  1  high from start-bit detect until return to IDLE
framing_error  output  1  one-cycle pulse when the stop bit samples 0
overrun  output  1  sticky; set if a byte completes while rx_valid=1; cleared on accept
parity_error  output  1  one-cycle pulse on parity mismatch (feature only; otherwise tied 0)

Behaviour:
- Clock clk; reset n_rst is asynchronous and active-low. Reset values: rx_data=0, rx_valid=0, rx_busy=0, framing_error=0, overrun=0, parity_error=0, state=IDLE, synchronizer flops=1.
- serial_in passes through a 2-flop synchronizer. All references to "line" below mean the synchronized value.
- bit_period is latched into period_q on the cycle a start edge is detected. Values below MIN_PERIOD are latched as MIN_PERIOD. Mid-frame changes are ignored.
- One down-counter. A "bit tick" occurs when the counter reaches 0; the counter then reloads.
- FSM states:
  - IDLE: when the line falls (prev=1, now=0), load the counter with (period_q>>1)-1 and go to START. rx_busy=1.
  - START: on tick, sample the line. If 0, load period_q-1 and go to DATA. If 1, treat it as a glitch, go to IDLE, and raise no error.
  - DATA: on each tick, shift the sampled bit into the MSB of the shift register (so the LSB arrives first). After DATA_BITS samples, go to STOP (or to PARITY with the feature).
  - STOP: on tick, sample the line.
    - If 1: the byte is good. Go to IDLE.
    - If 0: framing_error pulses for 1 cycle, the byte is discarded, and the FSM goes to BREAK.
  - BREAK: wait until the line=1, then go to IDLE. rx_busy stays 1.
- Byte delivery: on the cycle after a good stop sample, rx_data<=shift register and rx_valid<=1.
  - If rx_valid was already 1 at that point, overrun<=1, the new byte overwrites rx_data, and rx_valid stays 1.
- Handshake: rx_valid&rx_ready in a cycle = accept. rx_valid clears the next cycle and overrun clears with it.
  - If accept and a new delivery happen in the same cycle, the delivery wins: rx_valid stays 1, rx_data takes the new byte, and no overrun is flagged.
- Sampling is at mid-bit: the first data sample falls 1.5 bit periods (±1 clock) after the start edge.
- Resynchronization: the FSM re-arms in IDLE at the stop-bit midpoint. Back-to-back frames therefore need no idle gap.
- Reset mid-frame: everything returns to reset values immediately, and the partial byte is lost.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - A PARITY state is inserted between DATA and STOP, one bit tick long.
  - The expected bit is even parity, i.e. the XOR of the data bits.
  - On mismatch, parity_error pulses 1 cycle in the stop-sample cycle and the byte is discarded.
  - If the stop bit also fails, the framing error takes precedence: only framing_error pulses.
- Undefined: no PARITY state, and parity_error is constant 0.

Test Plan:
- bit_period=16, send 0xA5 8N1 with one idle bit after the stop bit, rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5 roughly 152 clocks after the start edge; framing_error=0, overrun=0.
- bit_period=16, send 0x3C then 0xC3 back-to-back, rx_ready=0 → after 0xC3 completes: rx_data=0xC3, rx_valid=1, overrun=1. Then rx_ready=1 for one cycle → rx_valid=0 and overrun=0 the next cycle.
- bit_period=16, drive serial_in low for 4 clocks then high → no rx_valid, no error, FSM back in IDLE (rx_busy=0) within 10 clocks.
- bit_period=16, send 0x55 with stop bit=0 then hold the line low for 40 clocks → framing_error pulses once and rx_valid stays 0. rx_busy stays 1 until the line returns high, after which a following 0x12 is received correctly.
- bit_period=2 → behaves as 4: 0x81 received correctly with a bit spacing of 4 clocks. Assert n_rst mid-DATA → all outputs 0 immediately, and the next frame is received correctly.
- UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 (wrong) → parity_error pulse and rx_valid=0. Send 0x07 with parity bit 1 → rx_data=0x07 and rx_valid=1.

Source files
------------

// File: rtl/uart_byte_rx_if.sv
// Byte handshake between uart_byte_rx (master, data source) and its consumer.
interface uart_byte_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial receiver with mid-bit sampling, valid/ready byte
// output, framing and overrun flags. Bit timing comes from bit_period, latched
// (and clamped to MIN_PERIOD) at each start edge.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_byte_rx #(
  parameter int DATA_BITS  = 8,
  parameter int BP_WIDTH   = 14,
  parameter int MIN_PERIOD = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                serial_in,
  input  logic [BP_WIDTH-1:0] bit_period,
  uart_byte_rx_if.master      rx_if,
  output logic                rx_busy,
  output logic                framing_error,
  output logic                overrun,
  output logic                parity_error
);
  localparam int BC_WIDTH = $clog2(DATA_BITS + 1);
  localparam logic [BP_WIDTH-1:0] ONE   = BP_WIDTH'(1);
  localparam logic [BP_WIDTH-1:0] P_MIN = BP_WIDTH'(MIN_PERIOD);
  localparam logic [BC_WIDTH-1:0] LAST_BIT = BC_WIDTH'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [BP_WIDTH-1:0]  period_q, period_d;
  logic [BP_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BC_WIDTH-1:0]  bits_q, bits_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 deliver_q, deliver_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_err_c;
  logic                 line, fall, tick, accept;
  logic [BP_WIDTH-1:0]  period_clamped;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_c;
`endif

  assign line           = sync2_q;
  assign fall           = prev_q & ~line;
  assign tick           = (cnt_q == '0);
  assign period_clamped = (bit_period < P_MIN) ? P_MIN : bit_period;
  assign accept         = valid_q & rx_if.rx_ready;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM next state: bit timing, data shift, stop/parity evaluation.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    cnt_d         = cnt_q;
    bits_d        = bits_q;
    shift_d       = shift_q;
    deliver_d     = 1'b0;
    framing_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
    parity_err_c  = 1'b0;
`endif
    // Counter runs only while timing a bit; a tick reloads a full period.
    if (state_q inside {START, DATA, PARITY, STOP})
      cnt_d = tick ? (period_q - ONE) : (cnt_q - ONE);
    case (state_q)
      IDLE: begin
        if (fall) begin
          // Half-period load puts every later tick at mid-bit.
          period_d = period_clamped;
          cnt_d    = (period_clamped >> 1) - ONE;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          bits_d  = '0;
          state_d = line ? IDLE : DATA;  // high at mid-start is a glitch
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          bits_d  = bits_q + BC_WIDTH'(1);
          if (bits_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = line;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          // Returning to IDLE at mid-stop lets the next start edge be caught
          // without any idle gap.
          if (!line) begin
            framing_err_c = 1'b1;
            state_d       = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_q != ^shift_q) begin
            parity_err_c = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      BREAK: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output handshake: a delivery always wins over a same-cycle accept.
  always_comb begin
    valid_d   = deliver_q | (valid_q & ~accept);
    overrun_d = ~accept & (overrun_q | (deliver_q & valid_q));
    data_d    = deliver_q ? shift_q : data_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      period_q  <= P_MIN;
      cnt_q     <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      deliver_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      deliver_q <= deliver_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_busy        = (state_q != IDLE);
  assign framing_error  = framing_err_c;
  assign overrun        = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error   = parity_err_c;
`else
  assign parity_error   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: table of good frames at several bit
// periods, then hand-written overrun, glitch, break, reset and parity cases.
`timescale 1ns/1ps
module tb_uart_byte_rx;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        serial_in;
  logic [13:0] bit_period;
  logic        rx_busy, framing_error, overrun, parity_error;

  uart_byte_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_byte_rx #(.DATA_BITS(8), .BP_WIDTH(14), .MIN_PERIOD(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .bit_period    (bit_period),
    .rx_if         (rx_if),
    .rx_busy       (rx_busy),
    .framing_error (framing_error),
    .overrun       (overrun),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [13:0] bp;
    int          per;       // effective clocks per bit after clamping
    logic [7:0]  exp_data;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc_no = 0;
  int         accept_cnt = 0;
  int         valid_hi_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         first_valid = -1;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observe outputs at the falling edge (inputs already settled), then advance one clock.
  task automatic cyc();
    logic [7:0] e;
    if (n_rst && rx_if.rx_valid) begin
      valid_hi_cnt++;
      if (first_valid < 0) first_valid = cyc_no;
      if (rx_if.rx_ready) begin
        accept_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, scoreboard empty", rx_if.rx_data);
        end else begin
          e = exp_q.pop_front();
          $display("rx byte %02h expected %02h", rx_if.rx_data, e);
          check("rx_data", {24'd0, rx_if.rx_data}, {24'd0, e});
        end
      end
    end
    if (n_rst) begin
      ferr_cnt += int'(framing_error);
      perr_cnt += int'(parity_error);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic send_bit(input logic b, input int per);
    serial_in = b;
    repeat (per) cyc();
  endtask

  // Start bit, LSB-first data, (correct parity if enabled), stop bit; line is left at stop value.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int per);
    send_bit(1'b0, per);
    for (int i = 0; i < 8; i++) send_bit(d[i], per);
`ifdef UART_RX_PARITY_EN
    send_bit(^d, per);
`endif
    send_bit(stop, per);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic pbit, input int per);
    send_bit(1'b0, per);
    for (int i = 0; i < 8; i++) send_bit(d[i], per);
    send_bit(pbit, per);
    send_bit(1'b1, per);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   a0, v0, f0, p0, s0, lat, idle_at;
    logic busy_seen;

    tbl[0] = '{8'hA5, 14'd16, 16, 8'hA5};
    tbl[1] = '{8'h00, 14'd16, 16, 8'h00};
    tbl[2] = '{8'hFF, 14'd16, 16, 8'hFF};
    tbl[3] = '{8'h81, 14'd2,  4,  8'h81};
    tbl[4] = '{8'h5A, 14'd5,  5,  8'h5A};
    tbl[5] = '{8'h3C, 14'd4,  4,  8'h3C};
    tbl[6] = '{8'h96, 14'd3,  4,  8'h96};
    tbl[7] = '{8'hE7, 14'd0,  4,  8'hE7};

    n_rst = 1'b0;
    serial_in = 1'b1;
    bit_period = 14'd16;
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    repeat (3) cyc();
    check("reset_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("reset_framing_error", {31'd0, framing_error}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_parity_error", {31'd0, parity_error}, 32'd0);
    n_rst = 1'b1;
    repeat (5) cyc();

    // Good frames, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      a0 = accept_cnt; v0 = valid_hi_cnt; f0 = ferr_cnt;
      bit_period = tbl[i].bp;
      exp_q.push_back(tbl[i].exp_data);
      first_valid = -1;
      s0 = cyc_no;
      send_frame(tbl[i].data, 1'b1, tbl[i].per);
      repeat (2 * tbl[i].per + 8) cyc();
      check("row_accepts", accept_cnt - a0, 1);
      check("row_valid_one_cycle", valid_hi_cnt - v0, 1);
      check("row_framing_error", ferr_cnt - f0, 0);
      check("row_overrun", {31'd0, overrun}, 32'd0);
      lat = first_valid - s0;
      checks++;
      if (first_valid < 0 || 2 * lat < (19 + 2 * PB) * tbl[i].per ||
          2 * lat > (19 + 2 * PB) * tbl[i].per + 12) begin
        errors++;
        $display("FAIL row_latency: got %0d clocks, expected about %0d", lat,
                 ((19 + 2 * PB) * tbl[i].per) / 2);
      end
    end

    // Back-to-back frames with no consumer: second overwrites first, overrun set.
    bit_period = 14'd16;
    rx_if.rx_ready = 1'b0;
    a0 = accept_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, 16);
    send_frame(8'hC3, 1'b1, 16);
    repeat (40) cyc();
    check("ovr_rx_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    check("ovr_rx_data", {24'd0, rx_if.rx_data}, 32'hC3);
    check("ovr_overrun", {31'd0, overrun}, 32'd1);
    rx_if.rx_ready = 1'b1;
    cyc();
    rx_if.rx_ready = 1'b0;
    check("ovr_accepts", accept_cnt - a0, 1);
    check("ovr_valid_cleared", {31'd0, rx_if.rx_valid}, 32'd0);
    check("ovr_overrun_cleared", {31'd0, overrun}, 32'd0);
    rx_if.rx_ready = 1'b1;
    repeat (4) cyc();

    // Short low glitch: start aborted at mid-bit, nothing reported.
    v0 = valid_hi_cnt; f0 = ferr_cnt;
    busy_seen = 1'b0;
    serial_in = 1'b0;
    repeat (4) begin cyc(); busy_seen |= rx_busy; end
    serial_in = 1'b1;
    idle_at = -1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      busy_seen |= rx_busy;
      if (!rx_busy && idle_at < 0) idle_at = i;
    end
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    checks++;
    if (idle_at < 0) begin
      errors++;
      $display("FAIL glitch_return_idle: rx_busy=%0b after 10 clocks, expected 0", rx_busy);
    end
    check("glitch_no_valid", valid_hi_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    repeat (20) cyc();

    // Stop bit low then line held low: one framing pulse, busy until line returns.
    a0 = accept_cnt; v0 = valid_hi_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h55, 1'b0, 16);
    repeat (40) cyc();
    check("brk_ferr_once", ferr_cnt - f0, 1);
    check("brk_no_valid", valid_hi_cnt - v0, 0);
    check("brk_busy", {31'd0, rx_busy}, 32'd1);
    check("brk_no_perr", perr_cnt - p0, 0);
    serial_in = 1'b1;
    repeat (8) cyc();
    check("brk_busy_released", {31'd0, rx_busy}, 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 16);
    repeat (40) cyc();
    check("brk_next_accepts", accept_cnt - a0, 1);

    // Reset mid-DATA with a held byte and overrun pending.
    bit_period = 14'd2;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h99, 1'b1, 4);
    send_frame(8'h66, 1'b1, 4);
    repeat (20) cyc();
    check("rst_pre_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    check("rst_pre_overrun", {31'd0, overrun}, 32'd1);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    send_bit(1'b0, 4);
    n_rst = 1'b0;
    #1;
    check("rst_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_framing_error", {31'd0, framing_error}, 32'd0);
    serial_in = 1'b1;
    repeat (3) cyc();
    n_rst = 1'b1;
    repeat (5) cyc();
    rx_if.rx_ready = 1'b1;
    a0 = accept_cnt;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 4);
    repeat (20) cyc();
    check("rst_next_accepts", accept_cnt - a0, 1);

`ifdef UART_RX_PARITY_EN
    // Parity: wrong bit discards the byte, right bit delivers it.
    bit_period = 14'd16;
    a0 = accept_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_frame_par(8'h07, 1'b0, 16);
    repeat (40) cyc();
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_no_accept", accept_cnt - a0, 0);
    check("par_bad_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check("par_bad_no_ferr", ferr_cnt - f0, 0);
    p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame_par(8'h07, 1'b1, 16);
    repeat (40) cyc();
    check("par_good_accepts", accept_cnt - a0, 1);
    check("par_good_no_perr", perr_cnt - p0, 0);
`else
    check("no_parity_pulses", perr_cnt, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
